// File: rtl/aes_pkg.sv
// Shared AES constants, helper arithmetic and the scheduler state type.
// No ports. Holds:
//   RCON_FIRST / RCON_LAST : round constants for expansion rounds 1 and 10
//   NR                     : AES-128 round count
//   xtime                  : GF(2^8) multiply by x
//   inv_xtime_rcon         : steps the round constant backwards
//   gf_mul                 : GF(2^8) multiply, used by the byte S-box
//   state_e                : scheduler FSM states
package aes_pkg;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam int         NR         = 10;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the round-constant chain is ever walked backwards. 0x1b is the
  // one place where xtime reduced, so it maps back to 0x80.
  function automatic logic [7:0] inv_xtime_rcon(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_rot_word.sv
// RotWord: cyclic left rotation of a 32-bit key word by one byte.
// Ports:
//   word_in  [31:0] in   word, byte 0 in bits [31:24]
//   word_out [31:0] out  rotated word
module aes_rot_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {word_in[23:0], word_in[31:24]};

endmodule

// File: rtl/aes_sub_word.sv
// Byte S-box (SubWord lane): multiplicative inverse in GF(2^8) followed by
// the AES affine transform.
// Ports:
//   in_byte  [7:0] in   byte to substitute
//   out_byte [7:0] out  S-box output
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // inverse = x^254 via a short square-and-multiply chain; 0 maps to 0
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, in_byte);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, in_byte);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, in_byte);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, in_byte);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, in_byte);
    inv  = gf_mul(x127, x127);
  end

  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/inv_key_scheduler_key_round_step.sv
// One AES-128 key expansion step, forward or inverted. Combinational.
// The four S-box lanes are shared by both directions: forward feeds w3,
// inverse feeds w3^w2 (the previous key's w3).
// Ports:
//   w0..w3  [31:0] in   current round key words
//   rcon    [7:0]  in   round constant of the step being applied/undone
//   dir            in   0 = forward (k -> k+1), 1 = inverse (k -> k-1)
//   key_nxt [127:0] out next key, w0 in [127:96]
module key_round_step
  import aes_pkg::*;
(
  input  logic [31:0]  w0,
  input  logic [31:0]  w1,
  input  logic [31:0]  w2,
  input  logic [31:0]  w3,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] key_nxt
);

  logic [31:0] sel_w, rot_w, sub_w, g_w;
  logic [31:0] n0, n1, n2, n3;

  assign sel_w = dir ? (w3 ^ w2) : w3;

  aes_rot_word u_rot (
    .word_in (sel_w),
    .word_out(rot_w)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sub_word u_sbox (
      .in_byte (rot_w[8*i +: 8]),
      .out_byte(sub_w[8*i +: 8])
    );
  end

  assign g_w = sub_w ^ {rcon, 24'h000000};

  always_comb begin
    if (dir) begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ g_w;
    end else begin
      n0 = w0 ^ g_w;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end
  end

  assign key_nxt = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_key_scheduler.sv
// AES-128 decryption key scheduler. Expands the cipher key forward to round
// key 10, then streams round keys 10..0 over valid/ready, regenerating each
// earlier key by undoing one expansion step.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   begin a new schedule (sampled in IDLE only)
//   key [0:127] in   cipher key, word 0 = bits [0:31]
//   out_ready   in   consumer accepts current round key
//   out_valid   out  round_key / round_idx valid
//   round_key   out  current round key (registered)
//   round_idx   out  round number of round_key
//   busy        out  high outside IDLE
//   done        out  one-cycle pulse after round key 0 is accepted
//
// state | meaning
// IDLE  | waiting for start; key register holds last emitted key
// FWD   | forward expansion, one round per clock, rnd 0 -> NR
// EMIT  | round key rnd presented; each accept steps back one round
module inv_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] key,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [0:127] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;
  logic [127:0] step_key;

  key_round_step u_step (
    .w0     (key_q[127:96]),
    .w1     (key_q[95:64]),
    .w2     (key_q[63:32]),
    .w3     (key_q[31:0]),
    .rcon   (rcon_q),
    .dir    (state_q == EMIT),
    .key_nxt(step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          rnd_d   = 4'd0;
          rcon_d  = RCON_FIRST;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = step_key;
        rnd_d = rnd_q + 4'd1;
        // hold the last constant so EMIT can undo round NR with it
        if (rcon_q != RCON_LAST) rcon_d = xtime(rcon_q);
        if (rnd_q == LAST_IDX - 4'd1) state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (rnd_q != 4'd0) begin
            key_d  = step_key;
            rnd_d  = rnd_q - 4'd1;
            rcon_d = inv_xtime_rcon(rcon_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      rcon_q  <= RCON_FIRST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign round_key = key_q;
  assign round_idx = rnd_q;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Bench for inv_key_scheduler. An independent FIPS-197 style expansion
// model pushes the expected keys (10 down to 0) when start is driven; a
// negedge monitor pops and compares on every accepted handshake, checks
// that stalled outputs hold, and that done follows round 0 exactly once.
module tb_inv_key_scheduler;

  typedef struct {
    logic [127:0] k;
    logic [3:0]   idx;
  } exp_t;

  localparam logic [7:0] RC [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n, start, out_ready, out_valid, busy, done;
  logic [127:0] key_in, round_key;
  logic [3:0]   round_idx;
  int           rdy_mode;

  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t exp_q[$];
  logic [7:0] sb [0:255];

  logic         prev_stall = 1'b0;
  logic [127:0] prev_key   = '0;
  logic [3:0]   prev_idx   = '0;
  logic         done_due   = 1'b0;

  always #5 clk = ~clk;

  inv_key_scheduler dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .key      (key_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .round_key(round_key),
    .round_idx(round_idx),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
  endtask

  task automatic push_expected(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    exp_t e;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {RC[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      e.k   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx = 4'(r);
      exp_q.push_back(e);
    end
  endtask

  // out_ready changes just after each rising edge
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      done_due   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_key", round_key, prev_key);
        chk("hold_idx", round_idx, prev_idx);
      end
      if (done || done_due) chk("done_pulse", done, done_due);
      if (done_due) begin
        chk("done_valid_low", out_valid, 0);
        chk("done_busy_low", busy, 0);
      end
      done_due = 1'b0;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("round_key", round_key, e.k);
          chk("round_idx", round_idx, e.idx);
          if (e.idx == 4'd0) done_due = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_key   = round_key;
      prev_idx   = round_idx;
    end
  end

  // start is sampled on the next rising edge; returns 2 time units after it
  task automatic do_start(input logic [127:0] k);
    @(posedge clk);
    #2;
    key_in = k;
    start  = 1'b1;
    push_expected(k);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // i counts negedges after the accepting edge
  task automatic run_op(input int budget, input int pa, input int pb, input logic [127:0] junk,
                        output int first_v, output int done_at,
                        output logic [127:0] k10, output logic [127:0] k9);
    first_v = -1;
    done_at = -1;
    k10 = '0;
    k9  = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = (i == pa) || (i == pb);
      if (start) begin
        chk("busy_at_pulse", busy, 1);
        key_in = junk;
      end
      if (out_valid && first_v < 0) first_v = i;
      if (out_valid && round_idx == 4'd10) k10 = round_key;
      if (out_valid && round_idx == 4'd9) k9 = round_key;
      if (done) begin
        done_at = i;
        break;
      end
    end
    chk("done_seen", done_at >= 0, 1);
  endtask

  initial begin
    int fv, da, da2;
    logic [127:0] k10, k9, ka, kb, kc, kr;
    logic found;

    build_sbox();
    rst_n = 1'b0; start = 1'b0; key_in = '0; out_ready = 1'b1; rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key", round_key, 0);
    chk("rst_idx", round_idx, 0);
    rst_n = 1'b1;

    // FIPS-197 key, ready tied high
    do_start(FIPS_KEY);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    run_op(60, -1, -1, '0, fv, da, k10, k9);
    chk("first_valid_lat", fv + 1, 10);
    chk("fips_k10", k10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_k9", k9, 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_done_at", da + 1, 21);

    // same key, random back-pressure
    rdy_mode = 1;
    do_start(FIPS_KEY);
    run_op(400, -1, -1, '0, fv, da, k10, k9);
    rdy_mode = 0;

    // start pulses while busy are ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    do_start(ka);
    run_op(60, 3, 15, kb, fv, da, k10, k9);
    chk("pulse_done_at", da, 21);

    // async reset while showing round 5
    kr = {$urandom, $urandom, $urandom, $urandom};
    do_start(kr);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && round_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_idx5", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_key", round_key, 0);
    chk("arst_idx", round_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end

    // all-zero key after reset
    do_start('0);
    run_op(60, -1, -1, '0, fv, da, k10, k9);
    chk("zero_k10", k10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_done_at", da, 21);

    // all-ones key, random back-pressure
    rdy_mode = 1;
    do_start({128{1'b1}});
    run_op(400, -1, -1, '0, fv, da, k10, k9);
    rdy_mode = 0;

    // back-to-back: start seen on the edge that accepts round 0 is ignored,
    // start on the following edge is accepted (22 edges after the first)
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    kc = {$urandom, $urandom, $urandom, $urandom};
    do_start(ka);
    da2 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 20) begin
        start  = 1'b1;
        key_in = kb;
      end
      if (i == 21) begin
        chk("b2b_done", done, 1);
        chk("b2b_busy_in_done", busy, 0);
        key_in = kc;
        push_expected(kc);
      end
      if (i == 22) begin
        start = 1'b0;
        chk("b2b_restart_busy", busy, 1);
      end
      if (i == 32) chk("b2b_second_idx10", {out_valid, round_idx}, {1'b1, 4'd10});
      if (i > 22 && done) begin
        da2 = i;
        break;
      end
    end
    chk("b2b_second_done_at", da2, 43);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
